// File: rtl/gray_pkg.sv
// Shared types and gray-code helpers for the gray stepping controller.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Operates on 32 bits; callers zero-extend narrower values and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_ctr.sv
// Binary up/down counter with registered gray-code output and wrap pulse.
module gray_updown_ctr
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = dir ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin  <= '0;
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_bin <= load_val;
        r_q   <= WIDTH'(bin2gray(32'(load_val)));
      end else if (en) begin
        r_bin  <= w_next;
        r_q    <= WIDTH'(bin2gray(32'(w_next)));
        // Wrap is detected on the binary value before the step.
        r_wrap <= dir ? (r_bin == '0) : (r_bin == '1);
      end
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: rtl/gray_step_ctrl.sv
// Runs a gray counter for a captured number of steps with pause/abort/load control.
//   state | meaning
//   IDLE  | no run; load and start accepted
//   RUN   | stepping once per edge until remaining count is exhausted
//   PAUSE | run held; resumes stepping on the first edge with pause low
module gray_step_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] len,
  input  logic             pause,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           r_state;
  logic [WIDTH-1:0] r_rem;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             w_active;
  logic             w_step;
  logic             w_load;

  always_comb begin
    w_active = (r_state != IDLE);
    w_step   = w_active && !abort && !pause && (r_rem != '0);
    w_load   = !w_active && load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !load) begin
            r_rem   <= len;
            r_dir   <= dir;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN, PAUSE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (pause) begin
            r_state <= PAUSE;
          end else if (r_rem <= WIDTH'(1)) begin
            // Covers both the final step and a zero-length run.
            r_rem   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem   <= r_rem - WIDTH'(1);
            r_state <= RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  gray_updown_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (w_step),
    .dir      (r_dir),
    .load     (w_load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed self-checking bench for gray_step_ctrl with WIDTH=4 and a 20 ns clock.
module tb_gray_step_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dir;
  logic [3:0] len;
  logic       pause;
  logic       abort;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       wrap;

  int errors;
  int checks;

  gray_step_ctrl #(.WIDTH(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .len      (len),
    .pause    (pause),
    .abort    (abort),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #50;
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b expected 0000", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    reset = 1'b1;
    tick();
    tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_idle_q: got %b expected 0000", q); end
  endtask

  task automatic test_up;
    logic [3:0] exp_q [5];
    int nbusy;
    exp_q[0] = 4'b0001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0010;
    exp_q[3] = 4'b0110; exp_q[4] = 4'b0111;
    start = 1'b1; len = 4'd5; dir = 1'b0;
    tick();
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL up_start_q: got %b expected 0000", q); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) nbusy++;
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL up_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
      checks++; if (done !== (i == 4)) begin errors++; $display("FAIL up_done[%0d]: got %b expected %b", i, done, (i == 4)); end
    end
    checks++; if (nbusy != 5) begin errors++; $display("FAIL up_busy_cycles: got %0d expected 5", nbusy); end
  endtask

  task automatic test_wrap;
    load_value(4'd15);
    checks++; if (q !== 4'b1000) begin errors++; $display("FAIL wrap_load_q: got %b expected 1000", q); end
    start = 1'b1; len = 4'd2; dir = 1'b0;
    tick();
    start = 1'b0;
    tick();
    checks++; if ({q, wrap, done} !== {4'b0000, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_step1: got q=%b wrap=%b done=%b expected q=0000 wrap=1 done=0", q, wrap, done); end
    tick();
    checks++; if ({q, wrap, done, busy} !== {4'b0001, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_step2: got q=%b wrap=%b done=%b busy=%b expected q=0001 wrap=0 done=1 busy=0", q, wrap, done, busy); end
  endtask

  task automatic test_pause;
    int nbusy;
    load_value(4'd0);
    start = 1'b1; len = 4'd4; dir = 1'b0;
    tick();
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    tick(); if (busy) nbusy++;
    tick(); if (busy) nbusy++;
    checks++; if (q !== 4'b0011) begin errors++; $display("FAIL pause_pre_q: got %b expected 0011", q); end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); if (busy) nbusy++;
      checks++; if ({q, done} !== {4'b0011, 1'b0}) begin errors++; $display("FAIL pause_hold[%0d]: got q=%b done=%b expected q=0011 done=0", i, q, done); end
    end
    pause = 1'b0;
    tick(); if (busy) nbusy++;
    checks++; if (q !== 4'b0010) begin errors++; $display("FAIL pause_resume_q: got %b expected 0010", q); end
    tick(); if (busy) nbusy++;
    checks++; if ({q, done} !== {4'b0110, 1'b1}) begin errors++; $display("FAIL pause_final: got q=%b done=%b expected q=0110 done=1", q, done); end
    checks++; if (nbusy != 7) begin errors++; $display("FAIL pause_busy_cycles: got %0d expected 7", nbusy); end
  endtask

  task automatic test_len0;
    start = 1'b1; len = 4'd0; dir = 1'b0;
    tick();
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL len0_t: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    tick();
    checks++; if ({q, busy, done} !== {4'b0110, 1'b0, 1'b1}) begin errors++; $display("FAIL len0_t1: got q=%b busy=%b done=%b expected q=0110 busy=0 done=1", q, busy, done); end
  endtask

  task automatic test_abort;
    load_value(4'd0);
    start = 1'b1; len = 4'd8; dir = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if (q !== 4'b0010) begin errors++; $display("FAIL abort_pre_q: got %b expected 0010", q); end
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    checks++; if ({q, busy, done} !== {4'b0010, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_edge: got q=%b busy=%b done=%b expected q=0010 busy=0 done=0", q, busy, done); end
    start = 1'b1; len = 4'd1; dir = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart_busy: got %b expected 1", busy); end
    tick();
    checks++; if ({q, done} !== {4'b0011, 1'b1}) begin errors++; $display("FAIL abort_restart_q: got q=%b done=%b expected q=0011 done=1", q, done); end
  endtask

  task automatic test_down_wrap;
    load_value(4'd0);
    start = 1'b1; len = 4'd1; dir = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if ({q, wrap, done} !== {4'b1000, 1'b1, 1'b1}) begin errors++; $display("FAIL down_wrap: got q=%b wrap=%b done=%b expected q=1000 wrap=1 done=1", q, wrap, done); end
  endtask

  task automatic test_load_start;
    load = 1'b1; load_val = 4'd5; start = 1'b1; len = 4'd3; dir = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    checks++; if ({q, busy} !== {4'b0111, 1'b0}) begin errors++; $display("FAIL load_start: got q=%b busy=%b expected q=0111 busy=0", q, busy); end
  endtask

  task automatic test_ignore_start;
    start = 1'b1; len = 4'd2; dir = 1'b0;
    tick();
    len = 4'd7; dir = 1'b1; load = 1'b1; load_val = 4'd0;
    tick();
    checks++; if ({q, busy} !== {4'b0101, 1'b1}) begin errors++; $display("FAIL busy_ignore_q: got q=%b busy=%b expected q=0101 busy=1", q, busy); end
    tick();
    start = 1'b0; load = 1'b0;
    checks++; if ({q, done, busy} !== {4'b0100, 1'b1, 1'b0}) begin errors++; $display("FAIL busy_ignore_done: got q=%b done=%b busy=%b expected q=0100 done=1 busy=0", q, done, busy); end
  endtask

  task automatic test_reset_mid;
    load_value(4'd0);
    start = 1'b1; len = 4'd8; dir = 1'b0;
    tick();
    start = 1'b0;
    tick();
    #4;
    reset = 1'b0;
    #1;
    checks++; if ({q, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin errors++; $display("FAIL reset_mid: got q=%b busy=%b done=%b expected q=0000 busy=0 done=0", q, busy, done); end
    #2;
    reset = 1'b1;
    tick();
    checks++; if ({q, busy} !== {4'b0000, 1'b0}) begin errors++; $display("FAIL reset_mid_after: got q=%b busy=%b expected q=0000 busy=0", q, busy); end
    start = 1'b1; len = 4'd1; dir = 1'b0;
    tick();
    start = 1'b0;
    tick();
    checks++; if ({q, done} !== {4'b0001, 1'b1}) begin errors++; $display("FAIL reset_mid_restart: got q=%b done=%b expected q=0001 done=1", q, done); end
  endtask

  initial begin
    errors = 0; checks = 0;
    start = 1'b0; dir = 1'b0; len = '0; pause = 1'b0;
    abort = 1'b0; load = 1'b0; load_val = '0; reset = 1'b0;
    test_reset();
    test_up();
    test_wrap();
    test_pause();
    test_len0();
    test_abort();
    test_down_wrap();
    test_load_start();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
